// File: rtl/instr_fetch_mem.sv
// Fetch-stage instruction memory: LATENCY-deep read pipeline with stall/flush,
// out-of-range fault reporting and a run-time loader write port.
module instr_fetch_mem #(
    parameter int unsigned  N          = 24,
    parameter int unsigned  DEPTH      = 256,
    parameter int unsigned  AW         = 24,
    parameter int unsigned  ADDR_SHIFT = 0,
    parameter int unsigned  LATENCY    = 1,
    parameter logic [N-1:0] NOP_WORD   = '0,
    parameter string        INIT_FILE  = ""
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    input  logic [AW-1:0]            req_addr,
    output logic                     req_ready,
    input  logic                     stall,
    input  logic                     flush,
    output logic                     rsp_valid,
    output logic [N-1:0]             instruction,
    output logic [AW-1:0]            rsp_addr,
    output logic                     fault,
    input  logic                     prog_we,
    input  logic [$clog2(DEPTH)-1:0] prog_addr,
    input  logic [N-1:0]             prog_data
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [N-1:0]  mem [DEPTH];
    logic [AW-1:0] idx;
    logic          in_range;
    logic          accept;
    logic [N-1:0]  rd_word;

    // Stage LATENCY-1 is the output register set.
    logic          st_valid [LATENCY];
    logic [N-1:0]  st_word  [LATENCY];
    logic [AW-1:0] st_addr  [LATENCY];
    logic          st_fault [LATENCY];

    if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
        $error("instr_fetch_mem: LATENCY must be in 1..4, got %0d", LATENCY);
    end

    // Power-up image: zeros.
    initial begin
        for (int i = 0; i < int'(DEPTH); i++) mem[i] = '0;
    end

    assign idx       = req_addr >> ADDR_SHIFT;
    assign in_range  = 64'(idx) < 64'(DEPTH);
    assign req_ready = ~stall & ~rst;
    assign accept    = req_valid & req_ready;
    // Combinational read sampled at the accepting edge gives read-before-write.
    assign rd_word   = in_range ? mem[PW'(idx)] : NOP_WORD;

    always_ff @(posedge clk) begin
        if (!rst && prog_we && (64'(prog_addr) < 64'(DEPTH))) begin
            mem[prog_addr] <= prog_data;
        end
    end

    // Flush clears every stage even under stall; data only moves with a valid beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(LATENCY); i++) begin
                st_valid[i] <= 1'b0;
                st_word[i]  <= '0;
                st_addr[i]  <= '0;
                st_fault[i] <= 1'b0;
            end
        end else if (flush || !stall) begin
            for (int i = 1; i < int'(LATENCY); i++) begin
                st_valid[i] <= flush ? 1'b0 : st_valid[i-1];
                if (st_valid[i-1] && !flush) begin
                    st_word[i]  <= st_word[i-1];
                    st_addr[i]  <= st_addr[i-1];
                    st_fault[i] <= st_fault[i-1];
                end
            end
            st_valid[0] <= accept;
            if (accept) begin
                st_word[0]  <= rd_word;
                st_addr[0]  <= req_addr;
                st_fault[0] <= ~in_range;
            end
        end
    end

    assign rsp_valid   = st_valid[LATENCY-1];
    assign instruction = st_word[LATENCY-1];
    assign rsp_addr    = st_addr[LATENCY-1];
    assign fault       = st_fault[LATENCY-1];

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Scoreboard bench for instr_fetch_mem: driver feeds a reference memory and an
// expected-response queue, an independent monitor checks every output cycle.
module tb_instr_fetch_mem;

    localparam int unsigned N     = 24;
    localparam int unsigned DEPTH = 256;
    localparam int unsigned AW    = 24;
    localparam int unsigned SH    = 2;
    localparam int unsigned LAT   = 3;
    localparam logic [N-1:0] NOP  = 24'h5A5A5A;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic          req_ready;
    logic          stall = 1'b0;
    logic          flush = 1'b0;
    logic          rsp_valid;
    logic [N-1:0]  instruction;
    logic [AW-1:0] rsp_addr;
    logic          fault;
    logic          prog_we = 1'b0;
    logic [7:0]    prog_addr = '0;
    logic [N-1:0]  prog_data = '0;

    always #5 clk = ~clk;

    instr_fetch_mem #(
        .N(N), .DEPTH(DEPTH), .AW(AW), .ADDR_SHIFT(SH), .LATENCY(LAT),
        .NOP_WORD(NOP), .INIT_FILE("")
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(req_ready), .stall(stall), .flush(flush),
        .rsp_valid(rsp_valid), .instruction(instruction), .rsp_addr(rsp_addr),
        .fault(fault), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data)
    );

    // left = advancing edges still needed before the fetch reaches the outputs
    typedef struct {
        logic [N-1:0]  word;
        logic [AW-1:0] addr;
        logic          fault;
        int            left;
    } exp_t;

    exp_t         q[$];
    logic [N-1:0] ref_mem [DEPTH];
    logic         e_rst = 1'b1, e_stall = 1'b0, e_flush = 1'b0;
    int           n_chk = 0, n_pass = 0;
    logic          last_v = 1'b0;
    logic [N-1:0]  last_w = '0;
    logic [AW-1:0] last_a = '0;
    logic          last_f = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Applies one cycle of inputs and advances the reference model across that edge.
    task automatic drive(input logic r, input logic rv, input logic [AW-1:0] addr,
                         input logic st, input logic fl, input logic we,
                         input logic [7:0] pa, input logic [N-1:0] pd);
        exp_t        e;
        int unsigned ix;
        @(negedge clk);
        #1;
        rst = r; req_valid = rv; req_addr = addr; stall = st; flush = fl;
        prog_we = we; prog_addr = pa; prog_data = pd;
        e_rst = r; e_stall = st; e_flush = fl;
        if (r || fl) q.delete();
        else if (!st) for (int k = 0; k < q.size(); k++) q[k].left = q[k].left - 1;
        if (rv && !st && !r) begin
            ix     = 32'(addr) >> SH;
            e.addr = addr;
            e.left = LAT - 1;
            if (ix >= DEPTH) begin e.word = NOP; e.fault = 1'b1; end
            else begin e.word = ref_mem[ix]; e.fault = 1'b0; end
            q.push_back(e);
        end
        if (we && !r) ref_mem[pa] = pd;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 8'd0, '0);
    endtask

    task automatic fetch(input logic [AW-1:0] a);
        drive(1'b0, 1'b1, a, 1'b0, 1'b0, 1'b0, 8'd0, '0);
    endtask

    // Monitor: after each edge, derive the expected outputs and compare.
    initial begin
        exp_t          e;
        logic          ev, ef;
        logic [N-1:0]  ew;
        logic [AW-1:0] ea;
        forever begin
            @(negedge clk);
            chk("req_ready", 32'(req_ready), 32'(!e_stall && !e_rst));
            if (e_rst) begin
                ev = 1'b0; ew = '0; ea = '0; ef = 1'b0;
            end else if (q.size() > 0 && q[0].left == 0) begin
                e  = q.pop_front();
                ev = 1'b1; ew = e.word; ea = e.addr; ef = e.fault;
            end else begin
                ev = (e_stall && !e_flush) ? last_v : 1'b0;
                ew = last_w; ea = last_a; ef = last_f;
            end
            chk("rsp_valid", 32'(rsp_valid), 32'(ev));
            chk("instruction", 32'(instruction), 32'(ew));
            chk("rsp_addr", 32'(rsp_addr), 32'(ea));
            chk("fault", 32'(fault), 32'(ef));
            last_v = ev; last_w = ew; last_a = ea; last_f = ef;
        end
    end

    initial begin
        drive(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 8'd0, '0);
        drive(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 8'd0, '0);
        for (int i = 0; i < int'(DEPTH); i++)
            drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 8'(i), N'($urandom));

        // Back-to-back fetches, then out-of-range fetches.
        for (int i = 0; i < 6; i++) fetch(AW'(i * 4));
        fetch(24'h400);
        fetch(24'hFFFFFC);
        idle(4);

        // Stall two cycles mid-stream with a request held at the input.
        fetch(24'h20); fetch(24'h24);
        drive(1'b0, 1'b1, 24'h28, 1'b1, 1'b0, 1'b0, 8'd0, '0);
        drive(1'b0, 1'b1, 24'h28, 1'b1, 1'b0, 1'b0, 8'd0, '0);
        fetch(24'h28);
        idle(4);

        // Flush with two in flight; the flush-cycle request is the redirect.
        fetch(24'h50); fetch(24'h54);
        drive(1'b0, 1'b1, 24'h10, 1'b0, 1'b1, 1'b0, 8'd0, '0);
        idle(4);

        // Flush together with stall drops everything and accepts nothing.
        fetch(24'h60); fetch(24'h64);
        drive(1'b0, 1'b1, 24'h68, 1'b1, 1'b1, 1'b0, 8'd0, '0);
        idle(4);

        // Same-cycle write and fetch of index 7, then refetch.
        drive(1'b0, 1'b1, 24'h1C, 1'b0, 1'b0, 1'b1, 8'd7, 24'hABCDEF);
        idle(1);
        fetch(24'h1C);
        idle(4);

        // Reset with three fetches in flight; loader write survives.
        fetch(24'h0); fetch(24'h4); fetch(24'h8);
        drive(1'b1, 1'b1, 24'hC, 1'b0, 1'b0, 1'b0, 8'd0, '0);
        idle(4);
        fetch(24'h1C);
        idle(4);

        for (int c = 0; c < 2000; c++) begin
            logic [AW-1:0] a;
            logic [7:0]    pa;
            a  = ($urandom_range(0, 9) == 0) ? AW'($urandom) : AW'($urandom_range(0, 1023));
            pa = ($urandom_range(0, 1) == 1) ? 8'(a >> SH) : 8'($urandom);
            drive($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 7, a,
                  $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 7,
                  $urandom_range(0, 99) < 20, pa, N'($urandom));
        end
        idle(6);
        @(negedge clk);
        #2;
        chk("drain", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
